alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of issued-operation counter.
REQ-002 SHALL have port: clk  input  1  single system clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: cmd_valid  input  1  command offered.
REQ-005 SHALL have port: cmd_ready  output  1  sequencer can accept a command.
REQ-006 SHALL have port: cmd_op  input  4  ALU opcode.
REQ-007 SHALL have ports: cmd_a, cmd_b  input  32 each  operands.
REQ-008 SHALL have ports: alu_a, alu_b  output  32 each  operands driven to the combinational ALU.
REQ-009 SHALL have port: alu_op  output  4  opcode driven to the ALU.
REQ-010 SHALL have ports: alu_result  input  32 and alu_zero  input  1  ALU outputs.
REQ-011 SHALL have ports: rsp_valid  output  1 and rsp_ready  input  1  response handshake.
REQ-012 SHALL have ports: rsp_result  output  32, rsp_zero  output  1, rsp_illegal  output  1  response payload.
REQ-013 SHALL have port: op_count  output  CNT_W  count of completed responses.

Function
REQ-014 SHALL use opcodes ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6; 7..15 illegal.
REQ-015 SHALL implement FSM IDLE, DRIVE, RESP; reset state IDLE.
REQ-016 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid && cmd_ready.
REQ-017 SHALL, on accept, register cmd_a/cmd_b/cmd_op onto alu_a/alu_b/alu_op and go IDLE->DRIVE.
REQ-018 SHALL hold alu_a/alu_b/alu_op stable from DRIVE until the next accept.
REQ-019 SHALL, in DRIVE, capture alu_result into rsp_result and alu_zero into rsp_zero, go DRIVE->RESP (ALU gets one full cycle to settle).
REQ-020 SHALL set rsp_illegal=1 when the captured opcode is 7..15, otherwise 0; illegal ops still complete normally.
REQ-021 SHALL assert rsp_valid only in RESP; payload stable while rsp_valid && !rsp_ready.
REQ-022 SHALL go RESP->IDLE on rsp_ready and increment op_count by 1 in that cycle, wrapping from all-ones to 0.
REQ-023 SHALL give latency of exactly 2 cycles from accept edge to rsp_valid high when rsp_ready is held high; maximum throughput one command per 3 cycles.
REQ-024 SHALL ignore cmd_valid outside IDLE (no buffering, no loss: cmd_ready is 0).

Reset
REQ-025 SHALL, on rst, immediately force state IDLE, cmd_ready=1 after release, rsp_valid=0, alu_a=alu_b=0, alu_op=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, op_count=0.
REQ-026 SHALL drop any in-flight command when rst asserts mid-DRIVE or mid-RESP; no response is produced for it.

Configuration
REQ-027 SHALL, when macro ALU_OP_SEQUENCER_CHECK_EN is defined, add output check_err (1 bit, reset 0) set sticky when the captured alu_result or alu_zero differs from a locally computed expected value (shift amount b[4:0], illegal op expects 0, zero=1).
REQ-028 SHALL, without ALU_OP_SEQUENCER_CHECK_EN, have no check_err port and no checking logic.

Structure
REQ-029 SHALL take opcode localparams, opcode width, and FSM state encoding from shared package alu_pkg.
REQ-030 SHALL place the expected-result computation in sub-module alu_ref_model, instantiated only under ALU_OP_SEQUENCER_CHECK_EN.

Verification
REQ-031 SHALL cover: accept ADD a=5 b=7, rsp_ready=1 -> rsp_valid 2 cycles later, rsp_result=12, rsp_zero=0, op_count=1.
REQ-032 SHALL cover: SUB a=b=32'hDEADBEEF -> rsp_result=0, rsp_zero=1.
REQ-033 SHALL cover: SLL a=1 b=32'h00000024 -> rsp_result=32'h00000010 (only b[4:0]=4 used).
REQ-034 SHALL cover: op=9 -> rsp_illegal=1, rsp_result=0, rsp_zero=1; rsp_ready held 0 for 5 cycles -> payload stable, cmd_ready=0.
REQ-035 SHALL cover: rst asserted in DRIVE -> all outputs reset values same cycle, no rsp_valid; op_count preset to 16'hFFFF then one response -> 0.
REQ-036 SHALL cover (CHECK_EN): ALU model forced to return XOR for OR op a=3 b=1 -> check_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode definitions and sequencer state encoding for the ALU operation sequencer.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Opcodes above SRL have no defined operation.
    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op > OP_SRL);
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational expected-result model used to cross-check the external ALU.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic [OP_W-1:0] op,
    output logic [31:0]     exp_result,
    output logic            exp_zero
);

    // Expected ALU output; illegal opcodes are expected to yield zero.
    always_comb begin
        exp_result = 32'd0;
        case (op)
            OP_ADD:  exp_result = a + b;
            OP_SUB:  exp_result = a - b;
            OP_AND:  exp_result = a & b;
            OP_OR:   exp_result = a | b;
            OP_XOR:  exp_result = a ^ b;
            OP_SLL:  exp_result = a << b[4:0];
            OP_SRL:  exp_result = a >> b[4:0];
            default: exp_result = 32'd0;
        endcase
        exp_zero = (exp_result == 32'd0);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time through an external combinational ALU (IDLE -> DRIVE -> RESP).
// Optional result cross-check enabled by macro ALU_OP_SEQUENCER_CHECK_EN (adds check_err output).
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] op_count
`ifdef ALU_OP_SEQUENCER_CHECK_EN
    ,
    output logic             check_err
`endif
);

    state_t             state_r;
    state_t             state_s;
    logic               accept_s;
    logic               complete_s;
    logic [31:0]        alu_a_r;
    logic [31:0]        alu_b_r;
    logic [3:0]         alu_op_r;
    logic [31:0]        rsp_result_r;
    logic               rsp_zero_r;
    logic               rsp_illegal_r;
    logic [CNT_W-1:0]   op_count_r;

    assign accept_s   = cmd_valid && (state_r == ST_IDLE);
    assign complete_s = rsp_ready && (state_r == ST_RESP);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DRIVE always lasts exactly one cycle so the ALU settles.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = ST_DRIVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: state_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // ALU operand registers: loaded on accept, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_r  <= 32'd0;
            alu_b_r  <= 32'd0;
            alu_op_r <= 4'd0;
        end else if (accept_s) begin
            alu_a_r  <= cmd_a;
            alu_b_r  <= cmd_b;
            alu_op_r <= cmd_op;
        end else begin
            alu_a_r  <= alu_a_r;
            alu_b_r  <= alu_b_r;
            alu_op_r <= alu_op_r;
        end
    end

    // Response payload captured at the end of DRIVE and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result_r  <= 32'd0;
            rsp_zero_r    <= 1'b0;
            rsp_illegal_r <= 1'b0;
        end else if (state_r == ST_DRIVE) begin
            rsp_result_r  <= alu_result;
            rsp_zero_r    <= alu_zero;
            rsp_illegal_r <= op_is_illegal(alu_op_r);
        end else begin
            rsp_result_r  <= rsp_result_r;
            rsp_zero_r    <= rsp_zero_r;
            rsp_illegal_r <= rsp_illegal_r;
        end
    end

    // Completed-response counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_r <= {CNT_W{1'b0}};
        end else if (complete_s) begin
            op_count_r <= op_count_r + CNT_W'(1);
        end else begin
            op_count_r <= op_count_r;
        end
    end

    assign cmd_ready   = (state_r == ST_IDLE);
    assign rsp_valid   = (state_r == ST_RESP);
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_op      = alu_op_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_zero    = rsp_zero_r;
    assign rsp_illegal = rsp_illegal_r;
    assign op_count    = op_count_r;

`ifdef ALU_OP_SEQUENCER_CHECK_EN
    logic [31:0] exp_result_s;
    logic        exp_zero_s;
    logic        check_err_r;

    alu_ref_model u_ref (
        .a          (alu_a_r),
        .b          (alu_b_r),
        .op         (alu_op_r),
        .exp_result (exp_result_s),
        .exp_zero   (exp_zero_s)
    );

    // Sticky flag: set when the ALU disagrees with the local model during DRIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            check_err_r <= 1'b0;
        end else if ((state_r == ST_DRIVE) &&
                     ((alu_result != exp_result_s) || (alu_zero != exp_zero_s))) begin
            check_err_r <= 1'b1;
        end else begin
            check_err_r <= check_err_r;
        end
    end

    assign check_err = check_err_r;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with a behavioural ALU and response queue model.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_ready_w;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b;
    logic [31:0] alu_a, alu_b, alu_a_w, alu_b_w;
    logic [3:0]  alu_op, alu_op_w;
    logic [31:0] alu_result, alu_result_w;
    logic        alu_zero, alu_zero_w;
    logic        rsp_valid, rsp_valid_w;
    logic        rsp_ready;
    logic [31:0] rsp_result, rsp_result_w;
    logic        rsp_zero, rsp_zero_w, rsp_illegal, rsp_illegal_w;
    logic [15:0] op_count;
    logic [1:0]  op_count_w;
    logic        bad_or;
    logic        exp_chk;
`ifdef ALU_OP_SEQUENCER_CHECK_EN
    logic        check_err, check_err_w;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    // Behavioural ALU, optionally faulty (OR computes XOR).
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic bad);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return bad ? (a ^ b) : (a | b);
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result   = alu_fn(alu_op, alu_a, alu_b, bad_or);
    assign alu_zero     = (alu_result == 32'd0);
    assign alu_result_w = alu_fn(alu_op_w, alu_a_w, alu_b_w, bad_or);
    assign alu_zero_w   = (alu_result_w == 32'd0);

    alu_op_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .op_count(op_count)
`ifdef ALU_OP_SEQUENCER_CHECK_EN
        , .check_err(check_err)
`endif
    );

    // Narrow-counter copy exercises the all-ones to zero wrap in a short run.
    alu_op_sequencer #(.CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a_w), .alu_b(alu_b_w), .alu_op(alu_op_w),
        .alu_result(alu_result_w), .alu_zero(alu_zero_w),
        .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result_w), .rsp_zero(rsp_zero_w), .rsp_illegal(rsp_illegal_w),
        .op_count(op_count_w)
`ifdef ALU_OP_SEQUENCER_CHECK_EN
        , .check_err(check_err_w)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        check_val({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check_val({tag, "_alu_a"}, alu_a, 32'd0);
        check_val({tag, "_alu_b"}, alu_b, 32'd0);
        check_val({tag, "_alu_op"}, {28'd0, alu_op}, 32'd0);
        check_val({tag, "_rsp_result"}, rsp_result, 32'd0);
        check_val({tag, "_rsp_flags"}, {30'd0, rsp_zero, rsp_illegal}, 32'd0);
        check_val({tag, "_op_count"}, {16'd0, op_count}, 32'd0);
        check_val({tag, "_op_count_w"}, {30'd0, op_count_w}, 32'd0);
`ifdef ALU_OP_SEQUENCER_CHECK_EN
        check_val({tag, "_check_err"}, {31'd0, check_err}, 32'd0);
`endif
    endtask

    // Issues one command from a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic do_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [33:0] e;
        logic [31:0] res;
        res = alu_fn(op, a, b, bad_or);
        exp_q.push_back({(op > 4'd6), (res == 32'd0), res});
        check_val("ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        rsp_ready = (hold == 0);
        @(negedge clk);
        check_val("valid_drive", {31'd0, rsp_valid}, 32'd0);
        check_val("ready_drive", {31'd0, cmd_ready}, 32'd0);
        check_val("alu_a", alu_a, a);
        check_val("alu_b", alu_b, b);
        check_val("alu_op", {28'd0, alu_op}, {28'd0, op});
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_a = $urandom; cmd_b = $urandom; cmd_op = 4'($urandom);
        @(negedge clk);
        e = exp_q.pop_front();
        check_val("valid_resp", {31'd0, rsp_valid}, 32'd1);
        check_val("rsp_result", rsp_result, e[31:0]);
        check_val("rsp_zero", {31'd0, rsp_zero}, {31'd0, e[32]});
        check_val("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e[33]});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check_val("hold_ready", {31'd0, cmd_ready}, 32'd0);
            check_val("hold_result", rsp_result, e[31:0]);
            check_val("hold_flags", {30'd0, rsp_illegal, rsp_zero}, {30'd0, e[33:32]});
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_done++;
        check_val("op_count", {16'd0, op_count}, 32'(n_done % 65536));
        check_val("op_count_wrap", {30'd0, op_count_w}, 32'(n_done % 4));
        check_val("valid_idle", {31'd0, rsp_valid}, 32'd0);
        check_val("alu_a_hold", alu_a, a);
`ifdef ALU_OP_SEQUENCER_CHECK_EN
        check_val("check_err", {31'd0, check_err}, {31'd0, exp_chk});
`endif
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 32'd0; cmd_b = 32'd0;
        rsp_ready = 1'b1; bad_or = 1'b0; exp_chk = 1'b0;
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_rel");

        do_cmd(4'd0, 32'd5, 32'd7, 0);
        do_cmd(4'd1, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        do_cmd(4'd5, 32'd1, 32'h00000024, 0);
        do_cmd(4'd9, $urandom, $urandom, 5);
        for (int k = 0; k < 40; k++) begin
            do_cmd(4'($urandom_range(0, 15)), $urandom, 32'($urandom_range(0, 3)) * $urandom,
                   $urandom_range(0, 3));
        end

        // Reset in the middle of DRIVE drops the command.
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 32'd11; cmd_b = 32'd22; rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_drive");
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check_val("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_reset_outputs("post_rst");

        for (int k = 0; k < 6; k++) begin
            do_cmd(4'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 2));
        end

`ifdef ALU_OP_SEQUENCER_CHECK_EN
        bad_or = 1'b1;
        exp_chk = 1'b1;
        do_cmd(4'd3, 32'd3, 32'd1, 0);
        bad_or = 1'b0;
        do_cmd(4'd0, 32'd1, 32'd1, 0);
        rst = 1'b1;
        #1;
        check_val("check_err_rst", {31'd0, check_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
